// File: rtl/vram_scan_arbiter.sv
// Single-port VRAM arbiter: fixed-slot scan-out fetch with CPU request/ack in the free cycles.
// Optional define VRAM_CPU_BLANK_ONLY_EN restricts CPU accepts to vertical blank.
module vram_scan_arbiter #(
    parameter int unsigned H_DISP  = 256,
    parameter int unsigned V_DISP  = 240,
    parameter int unsigned H_TOTAL = 309,
    parameter int unsigned V_TOTAL = 262,
    parameter int unsigned DATA_W  = 8,
    parameter int unsigned ADDR_W  = 13
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [8:0]        hpos,
    input  logic [8:0]        vpos,
    input  logic              display_on,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ack,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    output logic              pix_out
);

    localparam int unsigned       PIX_BITS     = $clog2(DATA_W);
    localparam logic [9:0]        HTotal       = 10'(H_TOTAL);
    localparam logic [9:0]        HDisp        = 10'(H_DISP);
    localparam logic [9:0]        VDisp        = 10'(V_DISP);
    localparam logic [8:0]        VLast        = 9'(V_TOTAL - 1);
    localparam logic [ADDR_W-1:0] WordsPerLine = ADDR_W'(H_DISP / DATA_W);

    typedef enum logic [1:0] {
        StIdle,
        StIssueWait,
        StCapture,
        StDone
    } state_e;

    state_e              r_state, w_state_d;
    logic [ADDR_W-1:0]   r_ram_addr, w_ram_addr_d;
    logic                r_ram_we, w_ram_we_d;
    logic [DATA_W-1:0]   r_ram_wdata, w_ram_wdata_d;
    logic                r_cpu_ack, w_cpu_ack_d;
    logic [DATA_W-1:0]   r_cpu_rdata, w_cpu_rdata_d;
    logic                r_is_write;
    logic [1:0]          r_vtag;
    logic [DATA_W-1:0]   r_pix_word;

    logic [9:0]          w_tp_raw, w_tp, w_tl;
    logic                w_slot, w_blank_ok, w_accept;
    logic [ADDR_W-1:0]   w_vaddr;

    // Fetch three pixels ahead so the word lands exactly when hpos reaches tp.
    always_comb begin
        w_tp_raw = {1'b0, hpos} + 10'd3;
        w_tp     = w_tp_raw;
        w_tl     = {1'b0, vpos};
        if (w_tp_raw >= HTotal) begin
            w_tp = w_tp_raw - HTotal;
            w_tl = (vpos == VLast) ? 10'd0 : {1'b0, vpos} + 10'd1;
        end
    end

    assign w_slot  = (w_tp[PIX_BITS-1:0] == '0) && (w_tp < HDisp) && (w_tl < VDisp);
    assign w_vaddr = ADDR_W'(w_tl) * WordsPerLine + ADDR_W'(w_tp >> PIX_BITS);

`ifdef VRAM_CPU_BLANK_ONLY_EN
    assign w_blank_ok = ({1'b0, vpos} >= VDisp);
`else
    assign w_blank_ok = 1'b1;
`endif

    always_comb begin
        w_state_d     = r_state;
        w_ram_addr_d  = r_ram_addr;
        w_ram_we_d    = 1'b0;
        w_ram_wdata_d = r_ram_wdata;
        w_cpu_ack_d   = 1'b0;
        w_cpu_rdata_d = r_cpu_rdata;
        w_accept      = 1'b0;

        if (w_slot) begin
            w_ram_addr_d = w_vaddr;
        end

        case (r_state)
            StIdle: begin
                if (cpu_req && !w_slot && w_blank_ok) begin
                    w_accept      = 1'b1;
                    w_ram_addr_d  = cpu_addr;
                    w_ram_we_d    = cpu_we;
                    w_ram_wdata_d = cpu_wdata;
                    w_state_d     = StIssueWait;
                end
            end
            StIssueWait: begin
                w_state_d = StCapture;
            end
            StCapture: begin
                if (!r_is_write) begin
                    w_cpu_rdata_d = ram_rdata;
                end
                w_cpu_ack_d = 1'b1;
                w_state_d   = StDone;
            end
            StDone: begin
                w_state_d = StIdle;
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= StIdle;
            r_ram_addr  <= '0;
            r_ram_we    <= 1'b0;
            r_ram_wdata <= '0;
            r_cpu_ack   <= 1'b0;
            r_cpu_rdata <= '0;
            r_is_write  <= 1'b0;
            r_vtag      <= '0;
            r_pix_word  <= '0;
        end else begin
            r_state     <= w_state_d;
            r_ram_addr  <= w_ram_addr_d;
            r_ram_we    <= w_ram_we_d;
            r_ram_wdata <= w_ram_wdata_d;
            r_cpu_ack   <= w_cpu_ack_d;
            r_cpu_rdata <= w_cpu_rdata_d;
            // Tag bit 1 marks the cycle in which ram_rdata carries a video word.
            r_vtag      <= {r_vtag[0], w_slot};
            if (r_vtag[1]) begin
                r_pix_word <= ram_rdata;
            end
            if (w_accept) begin
                r_is_write <= cpu_we;
            end
        end
    end

    assign ram_addr  = r_ram_addr;
    assign ram_we    = r_ram_we;
    assign ram_wdata = r_ram_wdata;
    assign cpu_ack   = r_cpu_ack;
    assign cpu_rdata = r_cpu_rdata;
    assign pix_out   = display_on & r_pix_word[~hpos[PIX_BITS-1:0]];

endmodule

// File: tb/tb_vram_scan_arbiter.sv
// Scoreboard bench for vram_scan_arbiter: bench-owned sync generator, RAM model and
// frame-position reference model; directed scenarios followed by randomized CPU traffic.
module tb_vram_scan_arbiter;

    localparam int HT = 309;
    localparam int VT = 262;
    localparam int HD = 256;
    localparam int VD = 240;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [8:0]  hpos = '0;
    logic [8:0]  vpos = '0;
    logic        display_on;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [12:0] cpu_addr = '0;
    logic [7:0]  cpu_wdata = '0;
    logic        cpu_ack;
    logic [7:0]  cpu_rdata;
    logic [12:0] ram_addr;
    logic        ram_we;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata;
    logic        pix_out;

    vram_scan_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .hpos       (hpos),
        .vpos       (vpos),
        .display_on (display_on),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_ack    (cpu_ack),
        .cpu_rdata  (cpu_rdata),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .pix_out    (pix_out)
    );

    always #5 clk = ~clk;

    assign display_on = (int'(hpos) < HD) && (int'(vpos) < VD);

    // Sync generator; a pending load jumps to a new position and restarts run_len.
    int run_len = 0;
    bit load_pend = 1'b0;
    int load_h, load_v;
    always @(posedge clk) begin
        #1;
        if (load_pend) begin
            hpos = 9'(load_h);
            vpos = 9'(load_v);
            load_pend = 1'b0;
            run_len = 0;
        end else begin
            if (int'(hpos) == HT - 1) begin
                hpos = 9'd0;
                vpos = (int'(vpos) == VT - 1) ? 9'd0 : vpos + 9'd1;
            end else begin
                hpos = hpos + 9'd1;
            end
            run_len = reset ? 0 : run_len + 1;
        end
    end

    // Synchronous-read RAM, read-before-write.
    logic [7:0] vram   [0:8191];
    logic [7:0] shadow [0:8191];
    always @(posedge clk) begin
        ram_rdata <= vram[ram_addr];
        if (ram_we) vram[ram_addr] = ram_wdata;
    end

    typedef struct packed {bit we; logic [7:0] rd;} ack_exp_t;
    typedef struct packed {logic [12:0] a; logic [7:0] d;} wr_exp_t;
    ack_exp_t ack_q[$];
    wr_exp_t  wr_q[$];

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (hpos=%0d vpos=%0d t=%0t)",
                     name, got, exp, hpos, vpos, $time);
        end
    endtask

    // Reference: the fetch target is simply the frame position three clocks ahead.
    function automatic bit slot_at(input int h, input int v);
        int p, tl, tp;
        p  = (v * HT + h + 3) % (HT * VT);
        tl = p / HT;
        tp = p % HT;
        return (tp % 8 == 0) && (tp < HD) && (tl < VD);
    endfunction

    function automatic int vaddr_at(input int h, input int v);
        int p;
        p = (v * HT + h + 3) % (HT * VT);
        return (p / HT) * (HD / 8) + (p % HT) / 8;
    endfunction

    function automatic bit blank_ok(input int v);
`ifdef VRAM_CPU_BLANK_ONLY_EN
        return v >= VD;
`else
        return (v >= 0);
`endif
    endfunction

    function automatic bit exp_pix(input int h, input int v);
        logic [7:0] w;
        if (h < HD && v < VD) begin
            w = shadow[v * (HD / 8) + h / 8];
            return w[7 - h % 8];
        end
        return 1'b0;
    endfunction

    // Monitor: all DUT outputs sampled on the falling edge.
    int cyc = 0, ack_cnt = 0, we_cyc = 0;
    int prev_h = 0, prev_v = 0;
    bit prev_valid = 1'b0, prev_req = 1'b0;
    int last_fetch = 0;
    bit lf_valid = 1'b0;
    logic [7:0] last_rd = '0;
    always @(negedge clk) begin
        ack_exp_t ea;
        wr_exp_t  ew;
        cyc++;
        if (reset) begin
            last_fetch = 0;
            lf_valid   = 1'b1;
            last_rd    = '0;
            prev_valid = 1'b0;
        end else begin
            if (prev_valid) begin
                if (slot_at(prev_h, prev_v)) begin
                    check("fetch_addr", 32'(ram_addr), vaddr_at(prev_h, prev_v));
                    check("fetch_we", 32'(ram_we), 0);
                    last_fetch = vaddr_at(prev_h, prev_v);
                    lf_valid   = 1'b1;
                end else if (prev_req) begin
                    lf_valid = 1'b0;
                end else if (lf_valid) begin
                    check("hold_addr", 32'(ram_addr), last_fetch);
                end
            end
            if (ram_we) begin
                we_cyc = cyc;
                if (wr_q.size() == 0) begin
                    check("unexpected_we", 32'(ram_we), 0);
                end else begin
                    ew = wr_q.pop_front();
                    check("we_addr", 32'(ram_addr), 32'(ew.a));
                    check("we_data", 32'(ram_wdata), 32'(ew.d));
                end
            end
            if (cpu_ack) begin
                ack_cnt++;
                if (ack_q.size() == 0) begin
                    check("unexpected_ack", 32'(cpu_ack), 0);
                end else begin
                    ea = ack_q.pop_front();
                    if (ea.we) begin
                        check("wr_rdata_hold", 32'(cpu_rdata), 32'(last_rd));
                        check("wr_ack_timing", cyc - we_cyc, 2);
                    end else begin
                        check("rd_data", 32'(cpu_rdata), 32'(ea.rd));
                        last_rd = ea.rd;
                    end
                end
            end
            if (run_len >= 12) check("pix", 32'(pix_out), 32'(exp_pix(hpos, vpos)));
            prev_valid = 1'b1;
        end
        prev_h   = hpos;
        prev_v   = vpos;
        prev_req = cpu_req;
    end

    // All tasks start and return 2 time units after a rising edge.
    task automatic set_pos(input int h, input int v);
        load_h = h;
        load_v = v;
        load_pend = 1'b1;
        @(posedge clk);
        #2;
    endtask

    task automatic wait_pos(input int h, input int v);
        int n = 0;
        while (!(int'(hpos) == h && int'(vpos) == v) && n < HT * VT + 2) begin
            @(posedge clk);
            #2;
            n++;
        end
        if (n >= HT * VT + 2) check("wait_pos_timeout", 32'(hpos), h);
    endtask

    task automatic cpu_issue(input bit we, input logic [12:0] addr, input logic [7:0] data);
        int h0, v0, k, lat, p;
        bit seen;
        ack_exp_t e;
        wr_exp_t  w;
        h0 = hpos;
        v0 = vpos;
        k = 0;
        lat = 0;
        seen = 1'b0;
        while (k < HT * VT) begin
            p = (v0 * HT + h0 + k) % (HT * VT);
            if (!slot_at(p % HT, p / HT) && blank_ok(p / HT)) break;
            k++;
        end
        e.we = we;
        e.rd = shadow[addr];
        ack_q.push_back(e);
        if (we) begin
            w.a = addr;
            w.d = data;
            wr_q.push_back(w);
            shadow[addr] = data;
        end
        cpu_req = 1'b1;
        cpu_we = we;
        cpu_addr = addr;
        cpu_wdata = data;
        while (!seen && lat < k + 30) begin
            @(negedge clk);
            lat++;
            if (cpu_ack) seen = 1'b1;
        end
        check("ack_latency", lat, k + 4);
        @(posedge clk);
        #2;
        cpu_req = 1'b0;
        cpu_we = 1'($urandom);
        cpu_addr = 13'($urandom);
        cpu_wdata = 8'($urandom);
    endtask

    initial begin
        #20_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1);
    end

    initial begin
        int a0, rv, h, v, idle;
        logic [15:0] pat;
        for (int i = 0; i < 8192; i++) begin
            vram[i]   = 8'($urandom);
            shadow[i] = vram[i];
        end

        // Reset values
        repeat (3) @(posedge clk);
        #2;
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_we", 32'(ram_we), 0);
        check("rst_ram_wdata", 32'(ram_wdata), 0);
        check("rst_cpu_ack", 32'(cpu_ack), 0);
        check("rst_cpu_rdata", 32'(cpu_rdata), 0);
        check("rst_pix_out", 32'(pix_out), 0);
        reset = 1'b0;

        // Reset during ISSUE_WAIT of a CPU write drops it silently
`ifdef VRAM_CPU_BLANK_ONLY_EN
        rv = 250;
`else
        rv = 100;
`endif
        set_pos(40, rv);
        wait_pos(49, rv);
        begin
            wr_exp_t w;
            w.a = 13'h1ABC;
            w.d = 8'hC3;
            wr_q.push_back(w);
        end
        cpu_req = 1'b1;
        cpu_we = 1'b1;
        cpu_addr = 13'h1ABC;
        cpu_wdata = 8'hC3;
        @(posedge clk);
        #6;
        reset = 1'b1;
        cpu_req = 1'b0;
        #1;
        check("midrst_ram_addr", 32'(ram_addr), 0);
        check("midrst_ram_we", 32'(ram_we), 0);
        check("midrst_ram_wdata", 32'(ram_wdata), 0);
        check("midrst_cpu_ack", 32'(cpu_ack), 0);
        check("midrst_cpu_rdata", 32'(cpu_rdata), 0);
        check("midrst_pix_out", 32'(pix_out), 0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        a0 = ack_cnt;
        repeat (10) @(posedge clk);
        #2;
        check("no_ack_after_reset", ack_cnt - a0, 0);
        cpu_issue(1'b0, 13'h1ABC, 8'h00);

        // Frame wrap: word 0 fetched at hpos=306 of the last line
        vram[0] = 8'hA5;
        shadow[0] = 8'hA5;
        vram[1] = 8'h3C;
        shadow[1] = 8'h3C;
        set_pos(290, 261);
        wait_pos(307, 261);
        @(negedge clk);
        check("wrap_fetch_addr", 32'(ram_addr), 0);
        @(posedge clk);
        #2;
        wait_pos(0, 0);
        pat = 16'hA53C;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            check("wrap_pix", 32'(pix_out), 32'(pat[15 - i]));
        end
        @(posedge clk);
        #2;

        // Cycles that must not fetch: tp=256, and tl=240 at end of line 239
        set_pos(240, 239);
        wait_pos(254, 239);
        @(negedge clk);
        check("no_fetch_tp256", 32'(ram_addr), 7679);
        @(posedge clk);
        #2;
        wait_pos(307, 239);
        @(negedge clk);
        check("no_fetch_tl240", 32'(ram_addr), 7679);
        @(posedge clk);
        #2;

        // Blank-time write then read-back
        set_pos(0, 250);
        cpu_issue(1'b1, 13'h0100, 8'h5A);
        cpu_issue(1'b0, 13'h0100, 8'h00);
        check("rd_0100", 32'(cpu_rdata), 32'h5A);

`ifdef VRAM_CPU_BLANK_ONLY_EN
        // Request raised in active video stalls until vertical blank
        set_pos(0, 100);
        cpu_issue(1'b0, 13'h1E00, 8'h00);
        check("blank_accept_line", 32'(vpos), 240);
`else
        // Request raised in a video slot is deferred by one cycle
        set_pos(280, 9);
        wait_pos(5, 10);
        fork
            cpu_issue(1'b0, 13'h1F00, 8'h00);
            begin
                @(negedge clk);
                @(negedge clk);
                check("blocked_fetch_321", 32'(ram_addr), 321);
                @(negedge clk);
                check("blocked_cpu_addr", 32'(ram_addr), 32'h1F00);
            end
        join
`endif

        // Randomized CPU traffic at random frame positions
        for (int n = 0; n < 40; n++) begin
`ifdef VRAM_CPU_BLANK_ONLY_EN
            v = $urandom_range(259, 240);
`else
            v = $urandom_range(261, 0);
`endif
            h = $urandom_range(308, 0);
            set_pos(h, v);
            idle = $urandom_range(30, 0);
            for (int j = 0; j < idle; j++) begin
                @(posedge clk);
                #2;
            end
            cpu_issue(1'($urandom_range(1, 0)), 13'(7680 + $urandom_range(15, 0)),
                      8'($urandom));
        end

        repeat (20) @(posedge clk);
        #2;
        check("ack_q_drained", ack_q.size(), 0);
        check("wr_q_drained", wr_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
